// File: rtl/voice_mixer_if.sv
// rtl/voice_mixer_if.sv - voice mixer control/data bundle between the envelope stage and the DAC stage
interface voice_mixer_if #(
  parameter int VOICES = 4
);
  logic                       sample_tick;
  logic [VOICES*8-1:0]        voice_sample;
  logic [VOICES*8-1:0]        voice_volume;
  logic [VOICES-1:0]          voice_enable;
  logic [7:0]                 master_gain;
  logic                       overrun_clr;
  logic signed [15:0]         out_sample;
  logic                       out_valid;
  logic                       busy;
  logic                       overrun;

  // Producer side: drives the frame inputs, observes the mixed result
  modport master (
    output sample_tick, voice_sample, voice_volume, voice_enable, master_gain, overrun_clr,
    input  out_sample, out_valid, busy, overrun
  );

  // Mixer side
  modport slave (
    input  sample_tick, voice_sample, voice_volume, voice_enable, master_gain, overrun_clr,
    output out_sample, out_valid, busy, overrun
  );
endinterface

// File: rtl/voice_mixer.sv
// rtl/voice_mixer.sv - time-shared MAC voice mixer with master gain and output saturation
module voice_mixer #(
  parameter int VOICES = 4,
  parameter int IDX_W  = (VOICES > 1) ? $clog2(VOICES) : 1
) (
  input  logic           clk,
  input  logic           rst,
  voice_mixer_if.slave   bus
);

  // Accumulator carries IDX_W bits of headroom over one 17-bit product,
  // enough for VOICES worst-case products without wrapping.
  localparam int ACC_W = 17 + IDX_W;
  // Full-precision width of accumulator times 9-bit unsigned gain.
  localparam int MUL_W = ACC_W + 9;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VOICES - 1);

  typedef enum logic [1:0] {IDLE, MAC, FINAL} state_t;

  state_t                    state_q, state_d;
  logic [VOICES*8-1:0]       samp_q, samp_d;
  logic [VOICES*8-1:0]       vol_q, vol_d;
  logic [VOICES-1:0]         en_q, en_d;
  logic [7:0]                gain_q, gain_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic signed [15:0]        out_sample_q, out_sample_d;
  logic                      out_valid_q, out_valid_d;
  logic                      overrun_q, overrun_d;

  logic [7:0]                cur_samp;
  logic [7:0]                cur_vol;
  logic signed [16:0]        product;
  logic signed [MUL_W-1:0]   acc_ext;
  logic signed [MUL_W-1:0]   gain_ext;
  logic signed [MUL_W-1:0]   mult;
  logic signed [MUL_W-1:0]   scaled;
  logic signed [15:0]        sat_out;

  // Current voice's weighted sample; disabled voices contribute nothing
  always_comb begin
    cur_samp = samp_q[idx_q*8 +: 8];
    cur_vol  = vol_q[idx_q*8 +: 8];
    product  = $signed({{9{cur_samp[7]}}, cur_samp}) * $signed({9'b0, cur_vol});
    if (!en_q[idx_q]) begin
      product = '0;
    end
  end

  // Gain scaling at full width, floor shift, then clamp to 16-bit signed
  always_comb begin
    acc_ext  = $signed({{9{acc_q[ACC_W-1]}}, acc_q});
    gain_ext = $signed({{ACC_W{1'b0}}, 1'b0, gain_q});
    mult     = acc_ext * gain_ext;
    scaled   = mult >>> 6;
    if ((&scaled[MUL_W-1:15]) || !(|scaled[MUL_W-1:15])) begin
      sat_out = scaled[15:0];
    end else if (scaled[MUL_W-1]) begin
      sat_out = 16'sh8000;
    end else begin
      sat_out = 16'sh7fff;
    end
  end

  // Frame sequencing: snapshot on tick, one voice per cycle, then scale and publish
  always_comb begin
    state_d      = state_q;
    samp_d       = samp_q;
    vol_d        = vol_q;
    en_d         = en_q;
    gain_d       = gain_q;
    acc_d        = acc_q;
    idx_d        = idx_q;
    out_sample_d = out_sample_q;
    out_valid_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.sample_tick) begin
          samp_d  = bus.voice_sample;
          vol_d   = bus.voice_volume;
          en_d    = bus.voice_enable;
          gain_d  = bus.master_gain;
          acc_d   = '0;
          idx_d   = '0;
          state_d = MAC;
        end
      end
      MAC: begin
        acc_d = acc_q + {{(ACC_W-17){product[16]}}, product};
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = FINAL;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      FINAL: begin
        out_sample_d = sat_out;
        out_valid_d  = 1'b1;
        state_d      = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Overrun is sticky; a new overrun in the same cycle as a clear keeps it set
  always_comb begin
    overrun_d = overrun_q;
    if (bus.sample_tick && (state_q != IDLE)) begin
      overrun_d = 1'b1;
    end else if (bus.overrun_clr) begin
      overrun_d = 1'b0;
    end
  end

  // State and datapath registers; reset abandons any frame in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      samp_q       <= '0;
      vol_q        <= '0;
      en_q         <= '0;
      gain_q       <= '0;
      acc_q        <= '0;
      idx_q        <= '0;
      out_sample_q <= '0;
      out_valid_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      samp_q       <= samp_d;
      vol_q        <= vol_d;
      en_q         <= en_d;
      gain_q       <= gain_d;
      acc_q        <= acc_d;
      idx_q        <= idx_d;
      out_sample_q <= out_sample_d;
      out_valid_q  <= out_valid_d;
      overrun_q    <= overrun_d;
    end
  end

  assign bus.out_sample = out_sample_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.overrun    = overrun_q;

endmodule
